// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: I-cache reads and D-cache reads/writes share one port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflicts; default is fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int READ_DELAY = 10,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  localparam logic [7:0] RD_LAST = 8'(READ_DELAY);

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              owner_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mask;
  logic              grant_any, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // On a conflict, hand the port to whoever did not win last time.
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | ~last_d);
  end
`else
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req;
  end
`endif

  // Only the three supported strobe patterns pass data; anything else writes nothing.
  always_comb begin
    case (wstrb_q)
      4'b1111: mask = 32'hFFFF_FFFF;
      4'b0011: mask = 32'h0000_FFFF;
      4'b0001: mask = 32'h0000_00FF;
      default: mask = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = (grant_d && d_we) ? WR : RD_WAIT;
      RD_WAIT: if (cnt == RD_LAST) state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_rden  = (state == RD_WAIT) && (cnt == RD_LAST);
    mem_wren  = (state == WR);
    mem_wstrb = (mem_wren && mask != 32'h0) ? wstrb_q : 4'b0000;
    mem_wdata = mem_wren ? (wdata_q & mask) : 32'h0;
    mem_addr  = busy ? addr_q : '0;
    i_ack     = (state == RESP) && !owner_d;
    d_ack     = (state == RESP) && owner_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      owner_d <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_any) begin
          owner_d <= grant_d;
          addr_q  <= grant_d ? d_addr : i_addr;
          wstrb_q <= grant_d ? d_wstrb : 4'b0000;
          wdata_q <= grant_d ? d_wdata : 32'h0;
          cnt     <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  <= grant_d;
`endif
        end
        RD_WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_rden) begin
            if (owner_d) d_rdata <= mem_rdata;
            else         i_rdata <= mem_rdata;
          end
        end
        WR:      d_rdata <= 32'h0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences, randomized model check.
module tb_mem_port_arbiter;
  localparam int RD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        i_ack, d_ack, mem_rden, mem_wren, busy;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] rd_val;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] held_i = 32'h0, held_d = 32'h0;

  always #5 clk = ~clk;
  assign mem_rdata = mem_rden ? rd_val : 32'h0;

  mem_port_arbiter #(.READ_DELAY(RD), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdv;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_mwstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},   {30'h0, i_ack, d_ack}, 32'h0);
    check({tag, "_irdata"}, i_rdata, 32'h0);
    check({tag, "_drdata"}, d_rdata, 32'h0);
    check({tag, "_maddr"}, {16'h0, mem_addr}, 32'h0);
    check({tag, "_strobes"}, {26'h0, mem_rden, mem_wren, mem_wstrb}, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Reference model: expected results derived from the port rules, not the RTL structure.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] m = 32'h0;
    bit legal = (v.wstrb == 4'b1111) || (v.wstrb == 4'b0011) || (v.wstrb == 4'b0001);
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = v.wstrb[b] ? 8'hFF : 8'h00;
    r.we         = v.is_d & v.we;
    r.exp_lat    = r.we ? 2 : RD + 2;
    r.exp_mwdata = legal ? (v.wdata & m) : 32'h0;
    r.exp_mwstrb = legal ? v.wstrb : 4'b0000;
    r.exp_rdata  = r.we ? 32'h0 : v.rdv;
    return r;
  endfunction

  // Single transaction from an idle arbiter; called at a falling edge.
  task automatic run_txn(input vec_t v, input string tag);
    int ack_k = -1, stb_k = -1, stb_n = 0, busy_n = 0;
    bit stb_rd = 1'b0, wrong_ack = 1'b0;
    logic [15:0] stb_addr = 16'h0;
    logic [31:0] stb_wdata = 32'h0, rd = 32'h0;
    logic [3:0]  stb_wstrb = 4'h0;
    rd_val = v.rdv;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wstrb = v.wstrb; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int k = 1; k <= 300 && ack_k < 0; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_rden || mem_wren) begin
        stb_n++; stb_k = k; stb_rd = mem_rden; stb_addr = mem_addr;
        stb_wdata = mem_wdata; stb_wstrb = mem_wstrb;
      end
      if (v.is_d ? i_ack : d_ack) wrong_ack = 1'b1;
      if (v.is_d ? d_ack : i_ack) begin
        ack_k = k; rd = v.is_d ? d_rdata : i_rdata;
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check({tag, "_ack_latency"}, ack_k, v.exp_lat);
    check({tag, "_strobe_cycle"}, stb_k, v.exp_lat - 1);
    check({tag, "_strobe_count"}, stb_n, 1);
    check({tag, "_strobe_kind"}, {31'h0, stb_rd}, {31'h0, !v.we});
    check({tag, "_mem_addr"}, {16'h0, stb_addr}, {16'h0, v.addr});
    check({tag, "_rdata"}, rd, v.exp_rdata);
    check({tag, "_busy_cycles"}, busy_n, v.exp_lat);
    check({tag, "_other_ack"}, {31'h0, wrong_ack}, 32'h0);
    if (v.we) begin
      check({tag, "_mem_wdata"}, stb_wdata, v.exp_mwdata);
      check({tag, "_mem_wstrb"}, {28'h0, stb_wstrb}, {28'h0, v.exp_mwstrb});
    end
    if (v.is_d) held_d = v.exp_rdata; else held_i = v.exp_rdata;
    @(negedge clk);
    check({tag, "_idle_after"}, {31'h0, busy}, 32'h0);
    check({tag, "_held_i"}, i_rdata, held_i);
    check({tag, "_held_d"}, d_rdata, held_d);
  endtask

  // Invariants checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_ack && d_ack) begin n_tests++; n_fail++; $display("FAIL dual_ack: both acks high"); end
      if (mem_rden && mem_wren) begin n_tests++; n_fail++; $display("FAIL dual_strobe: rden and wren high"); end
      if (!busy && mem_addr != 16'h0) begin
        n_tests++; n_fail++; $display("FAIL idle_addr: got %h expected 0000", mem_addr);
      end
    end
  end

  vec_t tbl[6];

  initial begin
    int dk, ik, acks;
    bit ord[4];
    bit exp_ord[4];
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wstrb = 4'h0; d_wdata = 32'h0; rd_val = 32'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{1'b0, 1'b0, 16'h0040, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0, 4'h0, 32'hDEADBEEF, RD + 2};
    tbl[1] = '{1'b1, 1'b1, 16'h1234, 4'b0001, 32'hAABBCCDD, 32'h0, 32'h000000DD, 4'b0001, 32'h0, 2};
    tbl[2] = '{1'b1, 1'b1, 16'h2000, 4'b0101, 32'hAABBCCDD, 32'h0, 32'h0, 4'b0000, 32'h0, 2};
    tbl[3] = '{1'b1, 1'b0, 16'h0100, 4'h0, 32'h0, 32'h12345678, 32'h0, 4'h0, 32'h12345678, RD + 2};
    tbl[4] = '{1'b1, 1'b1, 16'h0008, 4'b1111, 32'h11223344, 32'h0, 32'h11223344, 4'b1111, 32'h0, 2};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFC, 4'b0011, 32'hAABBCCDD, 32'h0, 32'h0000CCDD, 4'b0011, 32'h0, 2};
    for (int t = 0; t < 6; t++) run_txn(tbl[t], $sformatf("vec%0d", t));

    // Simultaneous reads: D first, I granted in the idle cycle after d_ack.
    dk = -1; ik = -1;
    rd_val = 32'hCAFE0001;
    i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    for (int k = 1; k <= 100 && ik < 0; k++) begin
      @(negedge clk);
      if (mem_rden && dk < 0) check("conflict_first_addr", {16'h0, mem_addr}, 32'h0000_0300);
      if (d_ack) begin dk = k; d_req = 1'b0; rd_val = 32'hCAFE0002; end
      if (i_ack) begin ik = k; i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("conflict_d_ack", dk, RD + 2);
    check("conflict_i_ack", ik, 2 * (RD + 2) + 1);
    check("conflict_d_rdata", d_rdata, 32'hCAFE0001);
    check("conflict_i_rdata", i_rdata, 32'hCAFE0002);
    held_d = 32'hCAFE0001; held_i = 32'hCAFE0002;
    @(negedge clk);

    // Back-to-back conflicts with requests held high across acks.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    acks = 0; rd_val = 32'h5A5A0003;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int k = 1; k <= 400 && acks < 4; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        ord[acks] = d_ack;
        if (d_ack) held_d = rd_val; else held_i = rd_val;
        acks++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("rr_ack_count", acks, 4);
    for (int n = 0; n < 4; n++)
      check($sformatf("rr_grant%0d", n), {31'h0, ord[n]}, {31'h0, exp_ord[n]});
    @(negedge clk);
    check("rr_held_i", i_rdata, held_i);
    check("rr_held_d", d_rdata, held_d);

    // Reset in the middle of RD_WAIT aborts the read.
    i_req = 1'b1; i_addr = 16'h0040; rd_val = 32'h0BAD0BAD;
    repeat (5) @(negedge clk);
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check_zero("abort_rst1");
    @(negedge clk);
    check_zero("abort_rst2");
    rst = 1'b0;
    dk = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_ack || d_ack || mem_rden || mem_wren || busy) dk++;
    end
    check("abort_no_activity", dk, 0);
    held_i = 32'h0; held_d = 32'h0;

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      v.is_d  = 1'($urandom_range(0, 1));
      v.we    = v.is_d & 1'($urandom_range(0, 1));
      v.addr  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v.wstrb = 4'b1111;
        1: v.wstrb = 4'b0011;
        2: v.wstrb = 4'b0001;
        default: v.wstrb = 4'($urandom_range(0, 15));
      endcase
      v.wdata = $urandom;
      v.rdv   = $urandom;
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit-address, 32-bit-data memory port between the instruction-cache miss path (port I, read-only) and the data-cache miss/write-through path (port D, read/write with byte strobes).
- Serialises one transaction at a time and models the fixed memory read latency with an internal counter.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between both cache controllers and the unified memory model.

Parameters:
- READ_DELAY, 10, cycles spent in RD_WAIT before memory read data is sampled; legal range 1..255.
- ADDR_W, 16, address width.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- i_req  input  1  port I read request; held high until i_ack.
- i_addr  input  ADDR_W  port I read address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  output  32  read data returned to port I.
- d_req  input  1  port D request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  ADDR_W  port D address.
- d_wstrb  input  4  byte enables for writes (1111, 0011 or 0001).
- d_wdata  input  32  port D write data.
- d_ack  output  1  one-cycle pulse on completion.
- d_rdata  output  32  read data returned to port D; 0 for writes.
- mem_addr  output  ADDR_W  memory address.
- mem_rden  output  1  memory read strobe.
- mem_wren  output  1  memory write strobe.
- mem_wstrb  output  4  memory byte enables.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; valid combinationally while mem_rden=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, RD_WAIT, WR, RESP.
- Reset: state=IDLE, counter=0, owner=I, last_grant=I.
  - All outputs are 0 after reset: i_ack, d_ack, i_rdata, d_rdata, mem_addr, mem_rden, mem_wren, mem_wstrb, mem_wdata, busy.
  - Reset mid-transaction aborts it: no ack is issued and no mem strobe is asserted on the following cycle.
- IDLE, sampling requests:
  - No request: stay in IDLE.
  - Only one request high: grant that port.
  - Both high: grant D (fixed priority; see Optional Feature).
- IDLE, on grant:
  - Latch owner, address, strobes, data and direction into registers; inputs are not re-sampled until the next IDLE.
  - Next state is WR if the grant is D with d_we=1, otherwise RD_WAIT.
  - counter<=0.
- RD_WAIT:
  - counter increments each cycle.
  - When counter==READ_DELAY: mem_rden=1 for that single cycle, the latched mem_rdata goes to the owner's rdata register, and the next state is RESP.
  - Grant-to-ack latency for a read is READ_DELAY+2 cycles.
- WR:
  - mem_wren=1 for exactly one cycle.
  - mem_wdata = d_wdata AND byte mask. Mask is FFFFFFFF for wstrb 1111, 0000FFFF for 0011, 000000FF for 0001, and 0 for any other code.
  - mem_wstrb carries the latched strobe, except an illegal strobe is forced to 0000.
  - Next state is RESP. Grant-to-ack latency is 2 cycles.
- RESP:
  - Owner's ack=1 for exactly one cycle; the non-owner ack stays 0.
  - d_rdata is 0 for writes.
  - Next state is IDLE. Requests are not evaluated in RESP.
- rdata registers hold their value until the next completion for that port.
- mem_addr holds the latched address from grant through RESP and returns to 0 in IDLE.
- mem_rden and mem_wren are never high simultaneously, and never high outside RD_WAIT or WR respectively.
- Requester rule: req is deasserted the cycle after ack.
  - If req is still high in IDLE, it is treated as a new request.
- A request dropped before its ack is a protocol violation. The arbiter completes the latched transaction regardless.
- No starvation guarantee under fixed priority.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the port not in last_grant. last_grant updates on every grant. Consecutive back-to-back conflicts therefore alternate D, I, D, I.
- Undefined: fixed D-over-I priority. last_grant is not implemented.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-RD_WAIT -> all outputs 0; state is IDLE on release; no i_ack or d_ack is ever seen for the aborted request.
- Port I read: i_req with i_addr=0x0040, memory returns 0xDEADBEEF -> mem_rden is a single pulse 11 cycles after grant; i_ack=1 with i_rdata=0xDEADBEEF at grant+12; busy is high for 12 cycles.
- Port D byte write: d_we=1, d_addr=0x1234, d_wstrb=0001, d_wdata=0xAABBCCDD -> mem_wren is one pulse at grant+1 with mem_wdata=0x000000DD and mem_wstrb=0001; d_ack=1 at grant+2 with d_rdata=0.
- Illegal strobe: d_wstrb=0101 write -> mem_wren pulses with mem_wdata=0 and mem_wstrb=0000; d_ack is still issued.
- Conflict: i_req and d_req rise in the same cycle, both reads -> D is served first. I is granted in the IDLE cycle after d_ack and completes 12 cycles later. i_ack and d_ack are never high together.
- Repeated conflicts with ARB_ROUND_ROBIN_EN defined: requesters re-raise req immediately after each ack for four transactions -> grant order D, I, D, I. With the macro undefined, D is granted all four times.
